// File: rtl/operand_stage.sv
// +--------------------------------------------------------------------------+
// | operand_stage: registered srca/srcb select with bypass, load-use stall   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module operand_stage #(
  parameter int XLEN   = 64,
  parameter int NFWD   = 3,
  parameter int SCNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [XLEN-1:0]      rd1,
  input  logic [XLEN-1:0]      rd2,
  input  logic [1:0]           asel,
  input  logic [2:0]           bsel,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [5*NFWD-1:0]    fwd_rd,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      srca,
  output logic [XLEN-1:0]      srcb,
  output logic [XLEN-1:0]      sdata,
  output logic [SCNT_W-1:0]    stall_cnt
);

  localparam int c_SHW = $clog2(XLEN);

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   srca_q, srca_d;
  logic [XLEN-1:0]   srcb_q, srcb_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0]   a_fwd, b_fwd;
  logic              a_rdy, b_rdy;
  logic              hazard;
  logic              transfer;

  // Scan oldest to youngest so the lowest matching index overrides the rest.
  always_comb begin
    a_fwd = rd1;
    a_rdy = 1'b1;
    b_fwd = rd2;
    b_rdy = 1'b1;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs1) && (rs1 != 5'd0)) begin
        a_fwd = fwd_data[i*XLEN +: XLEN];
        a_rdy = fwd_rdy[i];
      end
      if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs2) && (rs2 != 5'd0)) begin
        b_fwd = fwd_data[i*XLEN +: XLEN];
        b_rdy = fwd_rdy[i];
      end
    end
    if (rs1 == 5'd0) a_fwd = '0;
    if (rs2 == 5'd0) b_fwd = '0;
  end

  always_comb begin
    hazard   = (use_rs1 && !a_rdy) || (use_rs2 && !b_rdy);
    in_ready = !hazard && !flush && (!out_valid_q || out_ready);
    transfer = in_valid && in_ready;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    sdata_d     = sdata_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (transfer) begin
      out_valid_d = 1'b1;
      sdata_d     = b_fwd;
      case (asel)
        2'd0:    srca_d = a_fwd;
        2'd1:    srca_d = pc;
        2'd2:    srca_d = imm;
        default: srca_d = '0;
      endcase
      case (bsel)
        3'd0:    srcb_d = b_fwd;
        3'd1:    srcb_d = imm;
        3'd2:    srcb_d = XLEN'(4);
        3'd3:    srcb_d = {{(XLEN-c_SHW){1'b0}}, b_fwd[c_SHW-1:0]};
        3'd4:    srcb_d = {{(XLEN-5){1'b0}}, b_fwd[4:0]};
        default: srcb_d = '0;
      endcase
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_valid && hazard && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      srca_q      <= '0;
      srcb_q      <= '0;
      sdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      sdata_q     <= sdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign srca      = srca_q;
  assign srcb      = srcb_q;
  assign sdata     = sdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_stage.sv
// +--------------------------------------------------------------------------+
// | tb_operand_stage: directed self-checking bench for operand_stage         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_operand_stage;

  localparam int XLEN   = 64;
  localparam int NFWD   = 3;
  localparam int SCNT_W = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      pc, imm, rd1, rd2;
  logic [4:0]           rs1, rs2;
  logic [1:0]           asel;
  logic [2:0]           bsel;
  logic                 use_rs1, use_rs2;
  logic [NFWD-1:0]      fwd_valid, fwd_rdy;
  logic [5*NFWD-1:0]    fwd_rd;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      srca, srcb, sdata;
  logic [SCNT_W-1:0]    stall_cnt;

  int checks = 0;
  int errors = 0;

  operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .SCNT_W(SCNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .asel(asel), .bsel(bsel), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_rdy(fwd_rdy), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .srca(srca), .srcb(srcb), .sdata(sdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; pc = '0; imm = '0; rd1 = '0; rd2 = '0;
    rs1 = '0; rs2 = '0; asel = '0; bsel = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    fwd_valid = '0; fwd_rdy = '0; fwd_rd = '0; fwd_data = '0; flush = 1'b0;
    out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_srca", srca, 0);
    chk("rst_srcb", srcb, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b1;
    step();

    // ADD with no forwarding
    in_valid = 1'b1; asel = 2'd0; bsel = 3'd0; rs1 = 5'd5; rs2 = 5'd6;
    rd1 = 64'd10; rd2 = 64'd3; use_rs1 = 1'b1; use_rs2 = 1'b1;
    #1 chk("add_in_ready", in_ready, 1);
    step();
    chk("add_out_valid", out_valid, 1);
    chk("add_srca", srca, 64'd10);
    chk("add_srcb", srcb, 64'd3);
    chk("add_sdata", sdata, 64'd3);
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", out_valid, 0);

    // Forward priority: youngest source wins
    in_valid = 1'b1; fwd_valid = 3'b011; fwd_rdy = 3'b111;
    fwd_rd = {5'd0, 5'd5, 5'd5}; fwd_data = {64'h0, 64'hBB, 64'hAA};
    step();
    chk("fwd_prio_srca", srca, 64'hAA);
    // x0 never forwarded; rs2 takes the older source; back-to-back issue
    rs1 = 5'd0; rs2 = 5'd5; fwd_rd = {5'd0, 5'd5, 5'd0};
    #1 chk("b2b_in_ready", in_ready, 1);
    step();
    chk("x0_srca", srca, 64'h0);
    chk("fwd1_srcb", srcb, 64'hBB);
    chk("fwd1_sdata", sdata, 64'hBB);
    chk("b2b_out_valid", out_valid, 1);
    in_valid = 1'b0;
    step();

    // Load-use: youngest match not ready, older ready match does not rescue
    in_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6; rd2 = 64'd3;
    fwd_rd = {5'd0, 5'd5, 5'd5}; fwd_rdy = 3'b110; fwd_valid = 3'b011;
    use_rs1 = 1'b0;
    #1 chk("nouse_in_ready", in_ready, 1);
    use_rs1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("lu_in_ready", in_ready, 0);
      step();
    end
    chk("lu_stall_cnt", stall_cnt, 3);
    chk("lu_out_valid", out_valid, 0);
    fwd_rdy = 3'b111;
    #1 chk("lu_release_ready", in_ready, 1);
    step();
    chk("lu_srca", srca, 64'hAA);
    chk("lu_out_valid2", out_valid, 1);
    chk("lu_stall_hold", stall_cnt, 3);

    // Shift amounts and constants
    fwd_valid = '0; rd2 = 64'hFFFF_FFFF_FFFF_FFC7; bsel = 3'd3;
    step();
    chk("shamt_full_c7", srcb, 64'd7);
    bsel = 3'd4;
    step();
    chk("shamt5_c7", srcb, 64'd7);
    rd2 = 64'h27; bsel = 3'd3;
    step();
    chk("shamt_full_27", srcb, 64'h27);
    bsel = 3'd4;
    step();
    chk("shamt5_27", srcb, 64'd7);
    bsel = 3'd2;
    step();
    chk("const4", srcb, 64'd4);
    chk("sdata_any_bsel", sdata, 64'h27);
    asel = 2'd2; bsel = 3'd6; imm = 64'h55; rd1 = 64'h99;
    step();
    chk("imm_srca", srca, 64'h55);
    chk("bsel6_srcb", srcb, 64'h0);
    asel = 2'd3; bsel = 3'd5;
    step();
    chk("zero_srca", srca, 64'h0);
    chk("zero_srcb", srcb, 64'h0);
    asel = 2'd1; bsel = 3'd1; pc = 64'h1000;
    step();
    chk("pc_srca", srca, 64'h1000);
    chk("imm_srcb", srcb, 64'h55);

    // Backpressure holds outputs, then flush squashes
    out_ready = 1'b0; asel = 2'd0; rs1 = 5'd7; rd1 = 64'h77;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_srca", srca, 64'h1000);
      chk("bp_srcb", srcb, 64'h55);
    end
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_srca_hold", srca, 64'h1000);

    // Saturating stall counter; flushed cycles do not count
    rs1 = 5'd5; fwd_valid = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd5}; fwd_rdy = 3'b110;
    step(); step();
    chk("flush_no_count", stall_cnt, 3);
    flush = 1'b0;
    for (int k = 0; k < 11; k++) step();
    chk("cnt_14", stall_cnt, 14);
    for (int k = 0; k < 9; k++) step();
    chk("cnt_sat", stall_cnt, 15);

    // Asynchronous reset mid-stream
    fwd_rdy = 3'b111; out_ready = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_cnt", stall_cnt, 0);
    chk("async_rst_srca", srca, 0);
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
